// File: rtl/wash_sequencer_if.sv
// Control inputs and display/actuator outputs of the wash phase controller.
// The master side (stimulus or upstream control) drives the key, strobe and power lines.
interface wash_sequencer_if;
  logic       tick_s;
  logic       start_pause;
  logic       Power;
  logic [7:0] water_level;
  logic [7:0] c_time;
  logic [7:0] a_time;
  logic [7:0] ct_time;
  logic       Auto_End;
  logic [2:0] phase;
  logic       valve_in;
  logic       valve_out;
  logic       motor;
  logic       beep;
  logic       auto_off;

  modport master (
    output tick_s, start_pause, Power,
    input  water_level, c_time, a_time, ct_time, Auto_End, phase,
    input  valve_in, valve_out, motor, beep, auto_off
  );

  modport slave (
    input  tick_s, start_pause, Power,
    output water_level, c_time, a_time, ct_time, Auto_End, phase,
    output valve_in, valve_out, motor, beep, auto_off
  );
endinterface

// File: rtl/wash_sequencer.sv
// Washing-machine phase controller: fill/wash/drain/rinse/spin sequencing on a 1 s strobe,
// with pause/resume, forced power-off idle and a DONE auto-off countdown. All outputs registered.
module wash_sequencer #(
  parameter int LEVEL_TARGET = 20,
  parameter int FILL_STEP    = 2,
  parameter int DRAIN_STEP   = 4,
  parameter int WASH_S       = 30,
  parameter int RINSE_S      = 20,
  parameter int SPIN_S       = 15,
  parameter int RINSES       = 1,
  parameter int BEEP_S       = 3,
  parameter int OFF_S        = 10
) (
  input  logic              clk,
  input  logic              reset,
  wash_sequencer_if.slave   bus
);
  localparam int FILL_T  = (LEVEL_TARGET + FILL_STEP - 1) / FILL_STEP;
  localparam int DRAIN_T = (LEVEL_TARGET + DRAIN_STEP - 1) / DRAIN_STEP;
  localparam int TOTAL   = (RINSES + 1) * (FILL_T + DRAIN_T) + WASH_S + RINSES * RINSE_S + SPIN_S;
  localparam logic [8:0] TOTAL_9  = 9'(TOTAL);
  localparam logic [7:0] A_IDLE   = 8'((TOTAL > 99) ? 99 : TOTAL);
  localparam logic [7:0] BEEP_LIM = 8'(OFF_S - BEEP_S);

  typedef enum logic [2:0] {
    PH_IDLE = 3'd0, PH_FILL = 3'd1, PH_WASH = 3'd2, PH_DRAIN = 3'd3,
    PH_RINSE = 3'd4, PH_SPIN = 3'd5, PH_DONE = 3'd6, PH_PAUSE = 3'd7
  } phase_t;

  phase_t     phase_reg, phase_next, ret_reg, ret_next;
  logic [1:0] rinse_reg, rinse_next;
  logic [7:0] level_reg, level_next, c_reg, c_next, ct_reg, ct_next;
  logic [8:0] total_reg, total_next;
  logic       auto_end_reg, auto_end_next, auto_off_reg, auto_off_next;
  logic [7:0] a_reg, a_next;
  logic       valve_in_reg, valve_in_next, valve_out_reg, valve_out_next;
  logic       motor_reg, motor_next, beep_reg, beep_next;

  logic [8:0] fill_sum;
  logic [7:0] fill_level, drain_level;

  assign fill_sum    = {1'b0, level_reg} + 9'(FILL_STEP);
  assign fill_level  = (fill_sum > 9'(LEVEL_TARGET)) ? 8'(LEVEL_TARGET) : fill_sum[7:0];
  assign drain_level = (level_reg > 8'(DRAIN_STEP)) ? level_reg - 8'(DRAIN_STEP) : 8'd0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_reg     <= PH_IDLE;
      ret_reg       <= PH_IDLE;
      rinse_reg     <= 2'd0;
      level_reg     <= 8'd0;
      c_reg         <= 8'd0;
      ct_reg        <= 8'd0;
      total_reg     <= TOTAL_9;
      auto_end_reg  <= 1'b0;
      auto_off_reg  <= 1'b0;
      a_reg         <= A_IDLE;
      valve_in_reg  <= 1'b0;
      valve_out_reg <= 1'b0;
      motor_reg     <= 1'b0;
      beep_reg      <= 1'b0;
    end else begin
      phase_reg     <= phase_next;
      ret_reg       <= ret_next;
      rinse_reg     <= rinse_next;
      level_reg     <= level_next;
      c_reg         <= c_next;
      ct_reg        <= ct_next;
      total_reg     <= total_next;
      auto_end_reg  <= auto_end_next;
      auto_off_reg  <= auto_off_next;
      a_reg         <= a_next;
      valve_in_reg  <= valve_in_next;
      valve_out_reg <= valve_out_next;
      motor_reg     <= motor_next;
      beep_reg      <= beep_next;
    end
  end

  always_comb begin
    phase_next    = phase_reg;
    ret_next      = ret_reg;
    rinse_next    = rinse_reg;
    level_next    = level_reg;
    c_next        = c_reg;
    ct_next       = ct_reg;
    total_next    = total_reg;
    auto_end_next = auto_end_reg;
    auto_off_next = 1'b0;
    if (!bus.Power) begin
      phase_next    = PH_IDLE;
      level_next    = 8'd0;
      c_next        = 8'd0;
      ct_next       = 8'd0;
      total_next    = TOTAL_9;
      auto_end_next = 1'b0;
    end else if (bus.start_pause) begin
      case (phase_reg)
        PH_IDLE, PH_DONE: begin
          phase_next    = PH_FILL;
          c_next        = 8'(FILL_T);
          total_next    = TOTAL_9;
          level_next    = 8'd0;
          rinse_next    = 2'(RINSES);
          ct_next       = 8'd0;
          auto_end_next = 1'b0;
        end
        PH_PAUSE: phase_next = ret_reg;
        default: begin
          ret_next   = phase_reg;
          phase_next = PH_PAUSE;
        end
      endcase
    end else if (bus.tick_s) begin
      case (phase_reg)
        PH_FILL, PH_WASH, PH_DRAIN, PH_RINSE, PH_SPIN: begin
          total_next = (total_reg == 9'd0) ? 9'd0 : total_reg - 9'd1;
          c_next     = c_reg - 8'd1;
          if (phase_reg == PH_FILL)  level_next = fill_level;
          if (phase_reg == PH_DRAIN) level_next = drain_level;
          if (c_reg == 8'd1) begin
            case (phase_reg)
              PH_FILL: begin
                // a fill is a rinse fill once the first drain has consumed a rinse count
                if (rinse_reg != 2'(RINSES)) begin
                  phase_next = PH_RINSE;
                  c_next     = 8'(RINSE_S);
                end else begin
                  phase_next = PH_WASH;
                  c_next     = 8'(WASH_S);
                end
              end
              PH_WASH, PH_RINSE: begin
                phase_next = PH_DRAIN;
                c_next     = 8'(DRAIN_T);
              end
              PH_DRAIN: begin
                if (rinse_reg != 2'd0) begin
                  phase_next = PH_FILL;
                  c_next     = 8'(FILL_T);
                  rinse_next = rinse_reg - 2'd1;
                end else begin
                  phase_next = PH_SPIN;
                  c_next     = 8'(SPIN_S);
                end
              end
              default: begin
                phase_next    = PH_DONE;
                c_next        = 8'd0;
                level_next    = 8'd0;
                total_next    = 9'd0;
                ct_next       = 8'(OFF_S);
                auto_end_next = 1'b1;
              end
            endcase
          end
        end
        PH_DONE: begin
          ct_next = ct_reg - 8'd1;
          if (ct_reg == 8'd1) begin
            phase_next    = PH_IDLE;
            auto_end_next = 1'b0;
            auto_off_next = 1'b1;
            total_next    = TOTAL_9;
          end
        end
        default: ;
      endcase
    end
  end

  // Output values are decoded from the next state so they land in registers with it.
  always_comb begin
    a_next         = (total_next > 9'd99) ? 8'd99 : total_next[7:0];
    valve_in_next  = (phase_next == PH_FILL);
    valve_out_next = (phase_next == PH_DRAIN) || (phase_next == PH_SPIN);
    motor_next     = (phase_next == PH_WASH) || (phase_next == PH_RINSE) || (phase_next == PH_SPIN);
    beep_next      = (phase_next == PH_DONE) && (ct_next > BEEP_LIM);
  end

  assign bus.water_level = level_reg;
  assign bus.c_time      = c_reg;
  assign bus.a_time      = a_reg;
  assign bus.ct_time     = ct_reg;
  assign bus.Auto_End    = auto_end_reg;
  assign bus.phase       = phase_reg;
  assign bus.valve_in    = valve_in_reg;
  assign bus.valve_out   = valve_out_reg;
  assign bus.motor       = motor_reg;
  assign bus.beep        = beep_reg;
  assign bus.auto_off    = auto_off_reg;
endmodule
